// File: rtl/alu_io_pkg.sv
// Shared definitions for the ALU result serializer: frame state encoding,
// data width and frame length helper.
package alu_io_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Start + 8 data + optional parity + stop.
  function automatic int unsigned frame_bits(input int unsigned parity_en);
    return 10 + ((parity_en != 0) ? 1 : 0);
  endfunction

endpackage

// File: rtl/alu_result_serializer_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each period with tick; clear holds the count at zero.
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic CLK,
  input  logic RESETb,
  input  logic clear,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  logic [15:0] cnt_q, cnt_d;

  // With CLKS_PER_BIT=1, LAST is zero and tick is high every cycle.
  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || tick) cnt_d = '0;
    else               cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RESETb) begin
    if (!RESETb) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/alu_result_serializer.sv
// Captures the accumulator on LOAD and sends it as a UART-style frame,
// LSB first, with optional even parity.
//
// state     | meaning
// ST_IDLE   | line high, waiting for LOAD (also the DONE cycle)
// ST_START  | start bit (TX=0)
// ST_DATA   | eight data bits, shift register bit 0 on TX
// ST_PARITY | even parity of the captured byte
// ST_STOP   | stop bit (TX=1), DONE pulses when it ends
module alu_result_serializer
  import alu_io_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 1
) (
  input  logic              CLK,
  input  logic              RESETb,
  input  logic              LOAD,
  input  logic [DATA_W-1:0] DATA,
  output logic              TX,
  output logic              BUSY,
  output logic              DONE,
  output logic [3:0]        BIT_IDX
);

  localparam logic [3:0] PAR_IDX  = 4'd9;
  localparam logic [3:0] STOP_IDX = 4'(frame_bits(PARITY_EN) - 1);

  state_e            state_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_q;
  logic [2:0]        cnt_q;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;
  logic [3:0]        idx_q;
  logic              timer_clr;
  logic              tick;

  // Timer sits at zero while idle so every frame starts on a fresh period.
  assign timer_clr = (state_q == ST_IDLE);

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .CLK    (CLK),
    .RESETb (RESETb),
    .clear  (timer_clr),
    .tick   (tick)
  );

  always_ff @(posedge CLK or negedge RESETb) begin
    if (!RESETb) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      par_q   <= 1'b0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (LOAD) begin
            shift_q <= DATA;
            par_q   <= ^DATA;
            state_q <= ST_START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            idx_q   <= '0;
          end else begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        ST_START: begin
          if (tick) begin
            state_q <= ST_DATA;
            cnt_q   <= '0;
            tx_q    <= shift_q[0];
            idx_q   <= 4'd1;
          end
        end
        ST_DATA: begin
          if (tick) begin
            shift_q <= shift_q >> 1;
            if (cnt_q == 3'd7) begin
              if (PARITY_EN != 0) begin
                state_q <= ST_PARITY;
                tx_q    <= par_q;
                idx_q   <= PAR_IDX;
              end else begin
                state_q <= ST_STOP;
                tx_q    <= 1'b1;
                idx_q   <= STOP_IDX;
              end
            end else begin
              cnt_q <= cnt_q + 3'd1;
              tx_q  <= shift_q[1];
              idx_q <= 4'(cnt_q) + 4'd2;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state_q <= ST_STOP;
            tx_q    <= 1'b1;
            idx_q   <= STOP_IDX;
          end
        end
        ST_STOP: begin
          if (tick) begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            idx_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign TX      = tx_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign BIT_IDX = idx_q;

endmodule
